// File: rtl/usb_rx_packet_parser_if.sv
// usb_rx_packet_parser_if: signal bundle between the RX FIFO / output buffer and the packet parser
//   RX FIFO side   : r_data, empty, rcving, r_error (to parser), r_enable (from parser)
//   output buffer  : buf_full (to parser), pld_data, pld_put (from parser)
//   packet result  : pid, token_addr, token_endp, pkt_done, pkt_type, pkt_err, pld_len
//   master = parser side, slave = FIFO/buffer/consumer side
interface usb_rx_packet_parser_if;
    logic [7:0] r_data;
    logic       empty;
    logic       rcving;
    logic       r_error;
    logic       buf_full;
    logic       r_enable;
    logic [3:0] pid;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic [7:0] pld_data;
    logic       pld_put;
    logic       pkt_done;
    logic [1:0] pkt_type;
    logic       pkt_err;
    logic [6:0] pld_len;
    modport master (
        input  r_data, empty, rcving, r_error, buf_full,
        output r_enable, pid, token_addr, token_endp, pld_data, pld_put,
               pkt_done, pkt_type, pkt_err, pld_len
    );
    modport slave (
        output r_data, empty, rcving, r_error, buf_full,
        input  r_enable, pid, token_addr, token_endp, pld_data, pld_put,
               pkt_done, pkt_type, pkt_err, pld_len
    );
endinterface

// File: rtl/usb_rx_packet_parser.sv
// usb_rx_packet_parser: pops USB RX FIFO bytes, validates PID, parses token/data/handshake packets
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : master modport; FIFO pop (r_enable), payload stream (pld_data/pld_put),
//           per-packet result (pkt_done with pkt_type/pkt_err/pld_len, pid, token fields)
module usb_rx_packet_parser #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                          clk,
    input  logic                          n_rst,
    usb_rx_packet_parser_if.master        bus
);
    typedef enum logic [3:0] {IDLE, PID, TOK1, TOK2, CHK, HSK, DATA, FLUSH, DONE} state_t;
    state_t      r_state, w_next;
    logic        w_pop, w_err, w_eop, w_pid_ok, w_emit, w_ovf, w_live;
    logic [7:0]  w_d;
    logic [1:0]  w_type;
    logic [3:0]  r_pid, r_endp;
    logic [6:0]  r_addr, r_len;
    logic [7:0]  r_pld, r_h0, r_h1;
    logic        r_put, r_err;
    logic [1:0]  r_type, r_hcnt;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;

    function automatic logic [4:0] f_crc5(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] x;
        x = c;
        for (int i = 0; i < 8; i++) x = {x[3:0], 1'b0} ^ ((d[i] ^ x[4]) ? 5'h05 : 5'h00);
        return x;
    endfunction

    function automatic logic [15:0] f_crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 0; i < 8; i++) x = {x[14:0], 1'b0} ^ ((d[i] ^ x[15]) ? 16'h8005 : 16'h0000);
        return x;
    endfunction

    assign w_d      = bus.r_data;
    assign w_eop    = !bus.rcving && bus.empty;
    assign w_pid_ok = w_d[7:4] == ~w_d[3:0];
    assign w_type   = !w_pid_ok ? 2'd0 :
                      (w_d[3:0] inside {4'h1, 4'h5, 4'h9, 4'hD}) ? 2'd1 :
                      (w_d[3:0] inside {4'h3, 4'hB}) ? 2'd2 :
                      (w_d[3:0] inside {4'h2, 4'hA, 4'hE}) ? 2'd3 : 2'd0;
    // A byte popped with two already held pushes the oldest one out as payload,
    // unless that byte would take the payload past MAX_PAYLOAD.
    assign w_ovf    = r_hcnt == 2'd2 && r_len == 7'(MAX_PAYLOAD);
    assign w_emit   = w_pop && r_state == DATA && r_hcnt == 2'd2 && !w_ovf;
    assign w_live   = r_state != IDLE && r_state != DONE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: w_next = bus.empty ? IDLE : PID;
            PID: begin
                w_pop  = !bus.empty;
                w_err  = bus.empty ? w_eop : w_type == 2'd0;
                w_next = bus.empty ? (w_eop ? DONE : PID) :
                         w_type == 2'd1 ? TOK1 : w_type == 2'd2 ? DATA :
                         w_type == 2'd3 ? HSK : FLUSH;
            end
            TOK1, TOK2: begin
                w_pop  = !bus.empty;
                w_err  = w_eop;
                w_next = !bus.empty ? (r_state == TOK1 ? TOK2 : CHK) : w_eop ? DONE : r_state;
            end
            CHK: begin
                w_err  = !bus.empty || (w_eop && r_crc5 != 5'h0C);
                w_next = !bus.empty ? FLUSH : w_eop ? DONE : CHK;
            end
            HSK: begin
                w_err  = !bus.empty;
                w_next = !bus.empty ? FLUSH : w_eop ? DONE : HSK;
            end
            DATA: begin
                w_pop  = !bus.empty && !bus.buf_full;
                w_err  = (w_pop && w_ovf) || (w_eop && (r_hcnt != 2'd2 || r_crc16 != 16'h800D));
                w_next = (w_pop && w_ovf) ? FLUSH : w_eop ? DONE : DATA;
            end
            FLUSH: begin
                w_pop  = !bus.empty;
                w_next = w_eop ? DONE : FLUSH;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pid   <= '0;
            r_addr  <= '0;
            r_endp  <= '0;
            r_pld   <= '0;
            r_put   <= 1'b0;
            r_type  <= '0;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_h0    <= '0;
            r_h1    <= '0;
            r_hcnt  <= '0;
            r_crc5  <= '0;
            r_crc16 <= '0;
        end else begin
            r_put <= w_emit;
            if (w_emit) begin
                r_pld <= r_h1;
                r_len <= r_len + 7'd1;
            end
            // Error flag restarts at each PID pop and then accumulates until the next one.
            r_err <= ((w_pop && r_state == PID) ? 1'b0 : r_err) | w_err | (w_live && bus.r_error);
            if (w_pop) begin
                case (r_state)
                    PID: begin
                        r_pid   <= w_d[3:0];
                        r_type  <= w_type;
                        r_len   <= '0;
                        r_hcnt  <= '0;
                        r_crc5  <= 5'h1F;
                        r_crc16 <= 16'hFFFF;
                    end
                    TOK1: begin
                        r_addr    <= w_d[6:0];
                        r_endp[0] <= w_d[7];
                        r_crc5    <= f_crc5(r_crc5, w_d);
                    end
                    TOK2: begin
                        r_endp[3:1] <= w_d[2:0];
                        r_crc5      <= f_crc5(r_crc5, w_d);
                    end
                    DATA: begin
                        r_h0    <= w_d;
                        r_h1    <= r_h0;
                        r_hcnt  <= (r_hcnt == 2'd2) ? 2'd2 : r_hcnt + 2'd1;
                        r_crc16 <= f_crc16(r_crc16, w_d);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.r_enable   = w_pop;
    assign bus.pid        = r_pid;
    assign bus.token_addr = r_addr;
    assign bus.token_endp = r_endp;
    assign bus.pld_data   = r_pld;
    assign bus.pld_put    = r_put;
    assign bus.pkt_done   = r_state == DONE;
    assign bus.pkt_type   = r_type;
    assign bus.pkt_err    = r_err;
    assign bus.pld_len    = r_len;
endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// tb_usb_rx_packet_parser: directed table-driven bench for usb_rx_packet_parser with a show-ahead FIFO model
module tb_usb_rx_packet_parser;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    usb_rx_packet_parser_if bus();
    usb_rx_packet_parser #(.MAX_PAYLOAD(64)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0] fifo [0:255];
    int wr = 0;
    int rd = 0;
    logic fifo_clr = 1'b0;
    assign bus.r_data = fifo[rd[7:0]];
    assign bus.empty  = rd == wr;
    always @(posedge clk) begin
        if (fifo_clr) rd <= wr;
        else if (bus.r_enable) rd <= rd + 1;
    end

    int pops = 0, nput = 0, ndone = 0, stall_bad = 0, stall_put = 0, pop_empty = 0;
    logic [7:0] cap [0:255];
    logic full_d = 1'b0;
    logic [1:0] d_type;
    logic       d_err;
    logic [6:0] d_len;
    logic [3:0] d_pid, d_endp;
    logic [6:0] d_addr;
    always @(negedge clk) begin
        full_d <= bus.buf_full;
        if (bus.r_enable) pops <= pops + 1;
        if (bus.r_enable && bus.empty) pop_empty <= pop_empty + 1;
        if (bus.buf_full && bus.r_enable) stall_bad <= stall_bad + 1;
        if (bus.buf_full && full_d && bus.pld_put) stall_put <= stall_put + 1;
        if (bus.pld_put) begin
            cap[nput[7:0]] <= bus.pld_data;
            nput <= nput + 1;
        end
        if (bus.pkt_done) begin
            ndone  <= ndone + 1;
            d_type <= bus.pkt_type;
            d_err  <= bus.pkt_err;
            d_len  <= bus.pld_len;
            d_pid  <= bus.pid;
            d_addr <= bus.token_addr;
            d_endp <= bus.token_endp;
        end
    end

    int n_cmp = 0, n_bad = 0;
    int p0, c0, d0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [87:0] b, input int n, input int i);
        return 8'(b >> (8 * (n - 1 - i)));
    endfunction

    task automatic push(input logic [7:0] b);
        fifo[wr[7:0]] = b;
        wr++;
    endtask

    task automatic mark();
        p0 = pops;
        c0 = nput;
        d0 = ndone;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (ndone == d0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (ndone == d0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no pkt_done within %0d cycles, expected one", nm, k);
        end
        #1 bus.r_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send(input string nm, input logic [87:0] b, input int n, input logic rerr);
        @(posedge clk);
        #1 mark();
        for (int i = 0; i < n; i++) push(byte_of(b, n, i));
        bus.rcving  = 1'b1;
        bus.r_error = rerr;
        @(posedge clk);
        #1 bus.rcving = 1'b0;
        wait_done(nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " r_enable"}, bus.r_enable, 0);
        chk({nm, " pid"}, bus.pid, 0);
        chk({nm, " token_addr"}, bus.token_addr, 0);
        chk({nm, " token_endp"}, bus.token_endp, 0);
        chk({nm, " pld_data"}, bus.pld_data, 0);
        chk({nm, " pld_put"}, bus.pld_put, 0);
        chk({nm, " pkt_done"}, bus.pkt_done, 0);
        chk({nm, " pkt_type"}, bus.pkt_type, 0);
        chk({nm, " pkt_err"}, bus.pkt_err, 0);
        chk({nm, " pld_len"}, bus.pld_len, 0);
    endtask

    typedef struct {
        string       nm;
        int          n;
        logic [87:0] b;
        logic        rerr;
        logic [1:0]  typ;
        logic [3:0]  pid;
        logic        tok;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        err;
        int          len;
        int          pops;
    } vec_t;
    localparam int NV = 16;
    vec_t v [NV];
    localparam logic [87:0] SETUP_DATA = 88'hC3_80_06_00_01_00_00_40_00_DD_94;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected summary first");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        v[0]  = '{"tok_setup",   3,  88'h2D0010,   1'b0, 2'd1, 4'hD, 1'b1, 7'd0, 4'd0, 1'b0, 0, 3};
        v[1]  = '{"tok_badcrc",  3,  88'h2D0011,   1'b0, 2'd1, 4'hD, 1'b1, 7'd0, 4'd2, 1'b1, 0, 3};
        v[2]  = '{"tok_in",      3,  88'h690510,   1'b0, 2'd1, 4'h9, 1'b1, 7'd5, 4'd0, 1'b1, 0, 3};
        v[3]  = '{"tok_extra",   4,  88'h2D001055, 1'b0, 2'd1, 4'hD, 1'b1, 7'd0, 4'd0, 1'b1, 0, 4};
        v[4]  = '{"tok_rerr",    3,  88'h2D0010,   1'b1, 2'd1, 4'hD, 1'b1, 7'd0, 4'd0, 1'b1, 0, 3};
        v[5]  = '{"tok_short",   2,  88'h2D00,     1'b0, 2'd1, 4'hD, 1'b0, 7'd0, 4'd0, 1'b1, 0, 2};
        v[6]  = '{"hsk_ack",     1,  88'hD2,       1'b0, 2'd3, 4'h2, 1'b0, 7'd0, 4'd0, 1'b0, 0, 1};
        v[7]  = '{"hsk_extra",   2,  88'hD200,     1'b0, 2'd3, 4'h2, 1'b0, 7'd0, 4'd0, 1'b1, 0, 2};
        v[8]  = '{"hsk_stall",   1,  88'h1E,       1'b0, 2'd3, 4'hE, 1'b0, 7'd0, 4'd0, 1'b0, 0, 1};
        v[9]  = '{"data_ok",     11, SETUP_DATA,   1'b0, 2'd2, 4'h3, 1'b0, 7'd0, 4'd0, 1'b0, 8, 11};
        v[10] = '{"data_badcrc", 11, 88'hC3_80_06_00_01_00_00_40_00_DD_95,
                                                   1'b0, 2'd2, 4'h3, 1'b0, 7'd0, 4'd0, 1'b1, 8, 11};
        v[11] = '{"data_zero",   3,  88'hC30000,   1'b0, 2'd2, 4'h3, 1'b0, 7'd0, 4'd0, 1'b0, 0, 3};
        v[12] = '{"data1_zero",  3,  88'h4B0000,   1'b0, 2'd2, 4'hB, 1'b0, 7'd0, 4'd0, 1'b0, 0, 3};
        v[13] = '{"data_short",  2,  88'hC300,     1'b0, 2'd2, 4'h3, 1'b0, 7'd0, 4'd0, 1'b1, 0, 2};
        v[14] = '{"bad_pid",     3,  88'h2C1122,   1'b0, 2'd0, 4'h0, 1'b0, 7'd0, 4'd0, 1'b1, 0, 3};
        v[15] = '{"rsvd_pid",    1,  88'hF0,       1'b0, 2'd0, 4'h0, 1'b0, 7'd0, 4'd0, 1'b1, 0, 1};
        for (int i = 0; i < 256; i++) fifo[i] = 8'h00;
        bus.rcving   = 1'b0;
        bus.r_error  = 1'b0;
        bus.buf_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(v[i].nm, v[i].b, v[i].n, v[i].rerr);
            chk({v[i].nm, " done_count"}, ndone - d0, 1);
            chk({v[i].nm, " pkt_type"}, d_type, v[i].typ);
            chk({v[i].nm, " pkt_err"}, d_err, v[i].err);
            chk({v[i].nm, " pld_len"}, d_len, v[i].len);
            chk({v[i].nm, " pops"}, pops - p0, v[i].pops);
            chk({v[i].nm, " puts"}, nput - c0, v[i].len);
            if (v[i].typ != 2'd0) chk({v[i].nm, " pid"}, d_pid, v[i].pid);
            if (v[i].tok) begin
                chk({v[i].nm, " token_addr"}, d_addr, v[i].addr);
                chk({v[i].nm, " token_endp"}, d_endp, v[i].endp);
            end
            ok = 1'b1;
            for (int j = 0; j < v[i].len; j++)
                if (cap[8'(c0 + j)] !== byte_of(v[i].b, v[i].n, 1 + j)) ok = 1'b0;
            chk({v[i].nm, " payload"}, ok, 1);
        end

        // buf_full stall in the middle of the setup data packet
        @(posedge clk);
        #1 mark();
        for (int i = 0; i < 11; i++) push(byte_of(SETUP_DATA, 11, i));
        bus.rcving = 1'b1;
        for (int k = 0; k < 100 && nput - c0 < 3; k++) @(posedge clk);
        #1 bus.buf_full = 1'b1;
        begin
            int sb, sp;
            sb = stall_bad;
            sp = stall_put;
            repeat (20) @(posedge clk);
            chk("stall puts_before_release", nput - c0, 4);
            chk("stall r_enable_while_full", stall_bad - sb, 0);
            chk("stall pld_put_while_full", stall_put - sp, 0);
        end
        #1 bus.buf_full = 1'b0;
        bus.rcving = 1'b0;
        wait_done("stall");
        chk("stall pkt_type", d_type, 2);
        chk("stall pkt_err", d_err, 0);
        chk("stall pld_len", d_len, 8);
        chk("stall pops", pops - p0, 11);
        chk("stall puts", nput - c0, 8);
        ok = 1'b1;
        for (int j = 0; j < 8; j++)
            if (cap[8'(c0 + j)] !== byte_of(SETUP_DATA, 11, 1 + j)) ok = 1'b0;
        chk("stall payload", ok, 1);

        // 66-byte payload overflows MAX_PAYLOAD=64
        @(posedge clk);
        #1 mark();
        push(8'hC3);
        for (int i = 0; i < 66; i++) push(8'(i));
        push(8'h00);
        push(8'h00);
        bus.rcving = 1'b1;
        @(posedge clk);
        #1 bus.rcving = 1'b0;
        wait_done("overflow");
        chk("overflow pkt_type", d_type, 2);
        chk("overflow pkt_err", d_err, 1);
        chk("overflow pld_len", d_len, 64);
        chk("overflow puts", nput - c0, 64);
        chk("overflow pops", pops - p0, 69);
        ok = 1'b1;
        for (int j = 0; j < 64; j++)
            if (cap[8'(c0 + j)] !== 8'(j)) ok = 1'b0;
        chk("overflow payload", ok, 1);

        // reset after TOK1 of an IN token, then a clean zero-length DATA0
        @(posedge clk);
        #1 mark();
        push(8'h69);
        push(8'h05);
        push(8'h10);
        bus.rcving = 1'b1;
        for (int k = 0; k < 50 && pops - p0 < 2; k++) @(posedge clk);
        #1;
        chk("midrst pre pid", bus.pid, 9);
        chk("midrst pre token_addr", bus.token_addr, 5);
        n_rst = 1'b0;
        #1 chk_zero("midrst");
        bus.rcving = 1'b0;
        @(posedge clk);
        #1 fifo_clr = 1'b1;
        @(posedge clk);
        #1 fifo_clr = 1'b0;
        n_rst = 1'b1;
        send("after_rst", 88'hC30000, 3, 1'b0);
        chk("after_rst pkt_type", d_type, 2);
        chk("after_rst pld_len", d_len, 0);
        chk("after_rst pkt_err", d_err, 0);
        chk("after_rst pops", pops - p0, 3);

        chk("pop_while_empty", pop_empty, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/usb_rx_packet_parser.md
Name: usb_rx_packet_parser

Overview:
- Consumer stage directly downstream of the USB receiver's RX FIFO. Pops received bytes, decodes and validates the PID, and classifies each packet as token, data or handshake.
- Token packets: extracts address and endpoint, checks CRC5.
- Data packets: strips the CRC16 bytes, checks CRC16, and streams payload bytes to the output buffer.
- Reports one packet-level result per packet.

Parameters:
MAX_PAYLOAD, 64, maximum data payload bytes; further bytes are treated as an overflow error.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
r_data  input  8  RX FIFO head byte; valid whenever empty=0 (show-ahead)
empty  input  1  RX FIFO empty
rcving  input  1  receiver is mid-packet; falls after EOP
r_error  input  1  receiver-flagged packet error (sticky until next packet)
buf_full  input  1  downstream output buffer cannot accept a byte
r_enable  output  1  pop RX FIFO head this cycle
pid  output  4  decoded PID[3:0] of the current/last packet
token_addr  output  7  token address
token_endp  output  4  token endpoint
pld_data  output  8  payload byte to the output buffer
pld_put  output  1  one-cycle strobe: pld_data valid
pkt_done  output  1  one-cycle strobe: packet finished
pkt_type  output  2  00 none, 01 token, 10 data, 11 handshake; valid with pkt_done
pkt_err  output  1  valid with pkt_done; packet bad (PID, CRC, length, overflow or r_error)
pld_len  output  7  payload byte count, excluding CRC; valid with pkt_done

Behaviour:
- Reset: every output is 0, and the FSM enters IDLE.
- Pop rule: r_enable = 1 only when empty=0 and the FSM is in a byte-consuming state. The byte is taken from r_data in that same cycle. No pops in DATA while buf_full=1.
- End of packet: detected as rcving=0 and empty=0 false, i.e. rcving=0 with empty=1, while in a post-PID state.
- States and transitions:
  - IDLE: on empty=0, go to PID.
  - PID: pop the byte. Check byte[7:4] == ~byte[3:0]; a mismatch goes to FLUSH.
    - PIDs 1, 5, 9, D (OUT, SOF, IN, SETUP) go to TOK1.
    - PIDs 3, B (DATA0, DATA1) go to DATA.
    - PIDs 2, A, E (ACK, NAK, STALL) go to HSK.
    - Anything else goes to FLUSH.
  - TOK1: pop the byte. token_addr = b[6:0], endp[0] = b[7]. Go to TOK2.
  - TOK2: pop the byte. endp[3:1] = b[2:0]. Go to CHK.
  - CHK: wait for end of packet. An extra byte arriving sets the error flag and goes to FLUSH. The CRC5 residual must equal 5'h0C.
  - HSK: wait for end of packet. Any extra byte is an error.
  - DATA: 2-byte hold line.
    - Each popped byte enters the hold line. When the hold line already holds 2 bytes, the oldest byte is emitted on pld_data with pld_put the next cycle, and the payload count is incremented.
    - At end of packet, the 2 held bytes are the CRC and are discarded.
    - Fewer than 2 bytes held at end of packet is an error.
    - A payload count exceeding MAX_PAYLOAD is an error; go to FLUSH.
    - The CRC16 residual must equal 16'h800D.
  - FLUSH: pop and discard until end of packet.
  - DONE: pkt_done for 1 cycle, then IDLE.
- pkt_err = OR of: bad PID, CRC mismatch, wrong length, overflow, r_error sampled at any point in the packet.
- CRC5:
  - Runs over the 16 token bits, LSB first per byte.
  - Init 5'h1F. Per bit: fb = bit ^ crc[4]; crc = {crc[3:0], 0} ^ (fb ? 5'h05 : 0).
- CRC16:
  - Same scheme: init 16'hFFFF, poly 16'h8005, over all bytes after the PID including the CRC bytes.
- Latency: pkt_done asserts 1 cycle after end of packet is detected.
- Payload bytes are already committed downstream even when pkt_err=1; the consumer must drop them.
- Token fields and pid hold their values until the next PID is decoded.
- A new PID byte is never consumed before pkt_done of the previous packet.
- Reset mid-packet: the FSM returns to IDLE and all strobes drop. The RX FIFO is not flushed by this block.

Test Plan:
- FIFO bytes 2D 00 10, rcving falls -> pkt_type=01, pid=D, token_addr=0, token_endp=0, pkt_err=0, exactly 3 r_enable pulses.
- Single byte D2 -> pkt_type=11, pid=2, pkt_err=0, pld_len=0, no pld_put.
- C3 80 06 00 01 00 00 40 00 DD 94 -> 8 pld_put strobes carrying 80 06 00 01 00 00 40 00 in order, pld_len=8, pkt_err=0. Repeat with 94 corrupted to 95 -> same 8 bytes, pkt_err=1.
- Byte 2C (bad PID complement) followed by 2 bytes -> all bytes popped, pkt_type=00, pkt_err=1, no pld_put.
- buf_full held high for 20 cycles in the middle of the data packet above -> r_enable stays low during the stall, no pld_put, byte order and count unchanged after release. Separately, DATA0 with 66 payload bytes -> pkt_err=1.
- n_rst asserted after TOK1 of a token packet -> all outputs 0 immediately. The next clean packet C3 00 00 -> pkt_type=10, pld_len=0, pkt_err=0.
